shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-position shift/rotate controller for the ALU's 128-bit shift path. Accepts one shift command (operand, operation, amount), then drives the existing single-position `shift_rotate_unit` once per clock until the requested amount is reached. It returns the final word with a done pulse. It sits between ALU control and the shift datapath, so the combinational unit stays a 1-position shifter.

## Interface
Parameters:
- `W`, 128: data width; matches the shift unit.
- `CNT_W`, 7: amount width; covers amounts 0..127.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: command strobe; sampled only in IDLE or DONE.
- `op`, input, 3: operation code.
  - 0 = sll, 1 = srl, 2 = sla, 3 = sra, 4 = rotl, 5 = rotr.
  - 6 and 7 are invalid.
- `amount`, input, CNT_W: number of single-position steps.
- `data_in`, input, W: operand.
- `busy`, output, 1: high while shifting (RUN).
- `done`, output, 1: one-cycle pulse when a command completes, including invalid ones.
- `err`, output, 1: one-cycle pulse, coincident with `done`, for an invalid `op`.
- `result`, output, W: final word; holds until the next accepted command.

## Operation
- States: IDLE, RUN, DONE, ERR.
- Accept: `start`=1 in IDLE or DONE.
  - Latch `op` and `amount` into internal registers.
  - Load `data_in` into the working register.
  - Next state: ERR if `op`≥6; else DONE if `amount`=0; else RUN.
- Inputs are ignored in RUN and ERR, including `start`.
- `op` and `amount` may change after acceptance without effect.
- RUN: each cycle, working register ← `shift_rotate_unit(reg, op_latched)` and counter decrements.
  - When counter = 1 on that edge: perform the last shift, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE unless `start` is accepted.
- ERR: `done`=1 and `err`=1 for one cycle, then IDLE.
  - The working register keeps the loaded operand.
  - `result` presents `data_in` unchanged.
- Single-position semantics, each step over the full W bits:
  - sll and sla: zero-fill from the LSB.
  - srl: zero-fill from the MSB.
  - sra: replicate the MSB.
  - rotl: MSB→LSB.
  - rotr: LSB→MSB.
- `result` is the working register. It is valid while `done`=1 and held until the next accept.
- Amounts ≥ W are legal. The register simply steps `amount` times, so rotates wrap modulo W.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `result`=0, counter=0.
- Latency: `done` is asserted exactly `amount`+1 cycles after the accepting edge. For `amount`=0, that is the cycle right after acceptance.
- `busy` is high for exactly `amount` cycles; it is never high for `amount`=0 or for an invalid op.
- Back-to-back: `start` during the DONE cycle is accepted. There are zero idle cycles between commands, and `done` drops in the next cycle.
- `rst` during RUN aborts immediately to reset values; no `done` is produced.
- `start` held high continuously re-issues after every DONE cycle.
- All outputs are registered.

## Structure
- Package `shift_seq_pkg` holds:
  - op code constants `OP_SLL`..`OP_ROTR` (3'd0..3'd5);
  - the state encoding (IDLE/RUN/DONE/ERR);
  - the default `W` and `CNT_W`.
- The ALU's op decode uses the same op constants.
- One sub-module: `shift_rotate_unit`, instantiated once.
  - Its `in` connects to the working register.
  - Its `sel` connects to the latched op.
- No other hierarchy; FSM, counter and register live in `shift_sequencer`.

## Test plan
- `data_in`=128'h1, op=0, amount=4:
  - `result`=128'h10.
  - `done` pulses 5 cycles after accept; `busy` high 4 cycles.
- `data_in`=128'h8000…0000, op=3, amount=4: `result`=128'hF800…0000 (sign replicated).
- `data_in`=128'h8000…0001, op=4, amount=1: `result`=128'h3.
  - Same operand with op=5, amount=129: `result`=128'hC000…0000.
- amount=0, op=1, `data_in`=128'hA5: `done` the next cycle, `result`=128'hA5, `busy` never high.
- op=6, `data_in`=128'h55: `err` and `done` pulse together the next cycle; `result`=128'h55; `busy`=0.
- Busy and reset checks:
  - Start op=0, amount=10; pulse `start` with new values at RUN cycle 3 → ignored, final `result` matches the first command.
  - Repeat the command and assert `rst` at RUN cycle 5 → all outputs 0 immediately, state IDLE, no `done`.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-position shift sequencer: op codes,
// FSM state encoding and default widths. The ALU op decode uses the same
// op constants, so keep this the single source of truth.
package shift_seq_pkg;

    // Default datapath width and step-counter width
    localparam int DEFAULT_W     = 128;
    localparam int DEFAULT_CNT_W = 7;

    // Operation codes (3'd6 and 3'd7 are invalid)
    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SLA  = 3'd2;
    localparam logic [2:0] OP_SRA  = 3'd3;
    localparam logic [2:0] OP_ROTL = 3'd4;
    localparam logic [2:0] OP_ROTR = 3'd5;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // True for the six defined operations
    function automatic logic op_is_valid(input logic [2:0] op_code);
        return (op_code <= OP_ROTR);
    endfunction

endpackage : shift_seq_pkg

// File: rtl/shift_rotate_unit.sv
// Combinational single-position shifter/rotator over the full word.
// Left-moving ops take bit i from bit i-1, right-moving ops take bit i from
// bit i+1; only the fill bit at the open end depends on the operation.
// Undefined select codes pass the input through unchanged.
module shift_rotate_unit
    import shift_seq_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] in,
    input  logic [2:0]   sel,
    output logic [W-1:0] out
);

    logic [W-1:0] left_word;
    logic [W-1:0] right_word;
    logic         lsb_fill;
    logic         msb_fill;

    // Fill bits for the vacated end of the word
    always_comb begin
        lsb_fill = 1'b0;
        msb_fill = 1'b0;
        if (sel == OP_ROTL) begin
            lsb_fill = in[W-1];
        end
        if (sel == OP_SRA) begin
            msb_fill = in[W-1];
        end else if (sel == OP_ROTR) begin
            msb_fill = in[0];
        end
    end

    // Per-bit neighbour wiring for the left- and right-moving words
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign left_word[gi] = lsb_fill;
            end else begin : g_lsb_n
                assign left_word[gi] = in[gi-1];
            end
            if (gi == W-1) begin : g_msb
                assign right_word[gi] = msb_fill;
            end else begin : g_msb_n
                assign right_word[gi] = in[gi+1];
            end
        end
    endgenerate

    // Direction select
    always_comb begin
        out = in;
        case (sel)
            OP_SLL, OP_SLA, OP_ROTL: out = left_word;
            OP_SRL, OP_SRA, OP_ROTR: out = right_word;
            default:                 out = in;
        endcase
    end

endmodule : shift_rotate_unit

// File: rtl/shift_sequencer.sv
// Multi-position shift/rotate controller. A command is latched on start
// (in IDLE or DONE), then the single-position unit is applied once per
// clock until the requested amount of steps has been taken. All outputs
// are registered; result is the working register itself.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic [W-1:0]     data_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     result
);

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]     work_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;
    logic [W-1:0]     step_next;

    // One step of the latched operation applied to the working register
    shift_rotate_unit #(
        .W (W)
    ) u_unit (
        .in  (work_reg),
        .sel (op_reg),
        .out (step_next)
    );

    // Sequencer FSM, step counter, working register and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_SLL;
            cnt_reg   <= '0;
            work_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            // done/err are single-cycle pulses unless re-armed below
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_reg   <= op;
                        cnt_reg  <= amount;
                        work_reg <= data_in;
                        if (!op_is_valid(op)) begin
                            // Operand is kept untouched and reported as-is
                            state_reg <= ST_ERR;
                            done_reg  <= 1'b1;
                            err_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else if (amount == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Inputs (including start) are ignored while stepping
                    work_reg <= step_next;
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_ERR: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign err    = err_reg;
    assign result = work_reg;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus random
// commands compared against a plain-arithmetic reference model.
module tb_shift_sequencer;

    localparam int W     = 128;
    localparam int CNT_W = 7;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] amount;
    logic [W-1:0]     data_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [W-1:0]     result;

    int n_checks;
    int n_fail;

    shift_sequencer #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: whole-amount shifts/rotates in one arithmetic expression
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int o, input int a);
        int k;
        k = a % W;
        case (o)
            0, 2:    return d << a;
            1:       return d >> a;
            3:       return $signed(d) >>> a;
            4:       return (d << k) | (d >> (W - k));
            5:       return (d >> k) | (d << (W - k));
            default: return d;
        endcase
    endfunction

    // Issue one command and observe it to completion (sampled at negedges).
    // lat counts cycles after the accepting edge (1 = first cycle after).
    // If inject_at > 0, a start pulse with junk values is driven at that cycle.
    task automatic issue(input logic [W-1:0] d, input logic [2:0] o, input logic [CNT_W-1:0] a,
                         input int inject_at,
                         output int lat, output int busy_n, output bit err_seen,
                         output bit stray_err, output logic [W-1:0] res, output bit timeout);
        @(negedge clk);
        start = 1'b1; op = o; amount = a; data_in = d;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom()); amount = CNT_W'($urandom()); data_in = rand_word();
        lat = 1; busy_n = 0; err_seen = 0; stray_err = 0; res = '0; timeout = 1;
        for (int i = 0; i < 400; i++) begin
            if (busy) busy_n++;
            if (done) begin
                err_seen = err; res = result; timeout = 0;
                break;
            end
            if (err) stray_err = 1;
            start = (lat == inject_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        $display("cmd op=%0d amt=%0d lat=%0d busy=%0d err=%0b res=%h", o, a, lat, busy_n, err_seen, res);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; amount = '0; data_in = '0;
        #1;
        n_checks++;
        if ({busy, done, err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy, done, err});
        end
        n_checks++;
        if (result !== '0) begin
            n_fail++; $display("FAIL reset_result got=%h exp=0", result);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, err} !== 3'b000 || result !== '0) begin
            n_fail++; $display("FAIL post_reset got=%b/%h exp=000/0", {busy, done, err}, result);
        end
    endtask

    task automatic test_sll();
        int lat, bn; bit es, se, to; logic [W-1:0] r;
        issue(128'h1, 3'd0, 7'd4, 0, lat, bn, es, se, r, to);
        n_checks++;
        if (to || r !== 128'h10) begin n_fail++; $display("FAIL sll_result got=%h exp=%h", r, 128'h10); end
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL sll_latency got=%0d exp=5", lat); end
        n_checks++;
        if (bn !== 4) begin n_fail++; $display("FAIL sll_busy_cycles got=%0d exp=4", bn); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || result !== 128'h10) begin
            n_fail++; $display("FAIL sll_hold got done=%b res=%h exp done=0 res=%h", done, result, 128'h10);
        end
    endtask

    task automatic test_sra();
        int lat, bn; bit es, se, to; logic [W-1:0] r;
        logic [W-1:0] exp_r;
        exp_r = {5'b11111, 123'd0};
        issue({1'b1, 127'd0}, 3'd3, 7'd4, 0, lat, bn, es, se, r, to);
        n_checks++;
        if (to || r !== exp_r) begin n_fail++; $display("FAIL sra_result got=%h exp=%h", r, exp_r); end
    endtask

    task automatic test_rotate();
        int lat, bn; bit es, se, to; logic [W-1:0] r;
        logic [W-1:0] d;
        d = {1'b1, 126'd0, 1'b1};
        issue(d, 3'd4, 7'd1, 0, lat, bn, es, se, r, to);
        n_checks++;
        if (to || r !== 128'h3) begin n_fail++; $display("FAIL rotl_result got=%h exp=%h", r, 128'h3); end
        // 129 does not fit the 7-bit amount; 129 mod 128 = 1 step, same as rotr by 129 mod W
        issue(d, 3'd5, CNT_W'(129), 0, lat, bn, es, se, r, to);
        n_checks++;
        if (to || r !== {2'b11, 126'd0}) begin
            n_fail++; $display("FAIL rotr_result got=%h exp=%h", r, {2'b11, 126'd0});
        end
    endtask

    task automatic test_zero_amount();
        int lat, bn; bit es, se, to; logic [W-1:0] r;
        issue(128'hA5, 3'd1, 7'd0, 0, lat, bn, es, se, r, to);
        n_checks++;
        if (to || r !== 128'hA5) begin n_fail++; $display("FAIL zero_result got=%h exp=a5", r); end
        n_checks++;
        if (lat !== 1 || bn !== 0) begin n_fail++; $display("FAIL zero_timing got lat=%0d busy=%0d exp 1/0", lat, bn); end
    endtask

    task automatic test_invalid_op();
        int lat, bn; bit es, se, to; logic [W-1:0] r;
        issue(128'h55, 3'd6, 7'd9, 0, lat, bn, es, se, r, to);
        n_checks++;
        if (to || es !== 1'b1 || lat !== 1) begin
            n_fail++; $display("FAIL err_pulse got err=%b lat=%0d exp err=1 lat=1", es, lat);
        end
        n_checks++;
        if (r !== 128'h55 || bn !== 0) begin
            n_fail++; $display("FAIL err_result got res=%h busy=%0d exp 55/0", r, bn);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL err_one_cycle got done=%b err=%b exp 0/0", done, err);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bn; bit es, se, to; logic [W-1:0] r;
        issue(128'hF0F0, 3'd0, 7'd10, 3, lat, bn, es, se, r, to);
        n_checks++;
        if (to || r !== ref_model(128'hF0F0, 0, 10) || lat !== 11) begin
            n_fail++; $display("FAIL busy_ignore got res=%h lat=%0d exp res=%h lat=11", r, lat, ref_model(128'hF0F0, 0, 10));
        end
        // the injected start was not queued either
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_ignore_tail got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        start = 1'b1; op = 3'd0; amount = 7'd10; data_in = 128'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);   // now in RUN cycle 5
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, err} !== 3'b000 || result !== '0) begin
            n_fail++; $display("FAIL abort_outputs got=%b/%h exp=000/0", {busy, done, err}, result);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL abort_no_done got activity=1 exp=0"); end
        $display("cmd reset abort during RUN observed");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d, exp_r;
        int hits;
        d = rand_word();
        exp_r = ref_model(d, 4, 2);
        @(negedge clk);
        start = 1'b1; op = 3'd4; amount = 7'd2; data_in = d;
        hits = 0;
        for (int lat = 1; lat <= 9; lat++) begin
            @(negedge clk);
            n_checks++;
            if (done !== (lat % 3 == 0) || (done && result !== exp_r)) begin
                n_fail++; $display("FAIL b2b_cycle%0d got done=%b res=%h exp done=%b res=%h",
                                   lat, done, result, (lat % 3 == 0), exp_r);
            end
            if (done) hits++;
        end
        $display("cmd held start rotl amt=2 done_pulses=%0d", hits);
        // zero-amount held start completes every cycle
        op = 3'd1; amount = 7'd0; data_in = 128'h77;
        @(negedge clk);   // finishes the in-flight rotl (DONE) and accepts amount=0
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || result !== 128'h77) begin
                n_fail++; $display("FAIL b2b_zero got done=%b busy=%b res=%h exp 1/0/77", done, busy, result);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int lat, bn; bit es, se, to; logic [W-1:0] r, d;
        logic [2:0] o; logic [CNT_W-1:0] a;
        bit valid;
        for (int t = 0; t < 25; t++) begin
            d = rand_word();
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom()) : CNT_W'($urandom_range(0, 12));
            valid = (o < 3'd6);
            issue(d, o, a, 0, lat, bn, es, se, r, to);
            n_checks++;
            if (to || r !== ref_model(d, int'(o), int'(a))) begin
                n_fail++; $display("FAIL rand%0d_result got=%h exp=%h", t, r, ref_model(d, int'(o), int'(a)));
            end
            n_checks++;
            if (lat !== (valid ? int'(a) + 1 : 1) || bn !== (valid ? int'(a) : 0) || es !== !valid || se) begin
                n_fail++; $display("FAIL rand%0d_timing got lat=%0d busy=%0d err=%b exp lat=%0d busy=%0d err=%b",
                                   t, lat, bn, es, valid ? int'(a) + 1 : 1, valid ? int'(a) : 0, !valid);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sll();
        test_sra();
        test_rotate();
        test_zero_amount();
        test_invalid_op();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_sequencer
